// File: rtl/fifo_lvl_pkg.sv
// fifo_lvl_pkg: shared pointer-width and depth-legality helpers for fifo_lvl
package fifo_lvl_pkg;
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
    function automatic bit depth_ok(input int depth);
        return depth >= 2 && (depth & (depth - 1)) == 0;
    endfunction
endpackage

// File: rtl/fifo_lvl_if.sv
// fifo_lvl_if: push/pop request and level/status bundle of fifo_lvl
interface fifo_lvl_if #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    import fifo_lvl_pkg::*;
    localparam int PW = ptr_w(FIFO_DEPTH);
    logic push, pop, flush, err_clr, ack;
    logic [FIFO_WIDTH-1:0] data_in, data_out;
    logic [PW-1:0] count;
    logic full, empty, almost_full, almost_empty, overflow, underflow;
    modport master (
        output push, data_in, pop, flush, err_clr,
        input  ack, data_out, count, full, empty, almost_full, almost_empty, overflow, underflow
    );
    modport slave (
        input  push, data_in, pop, flush, err_clr,
        output ack, data_out, count, full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_lvl_mem.sv
// fifo_lvl_mem: storage array with one synchronous write port and one asynchronous read port
module fifo_lvl_mem #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(FIFO_DEPTH)-1:0] waddr,
    input  logic [FIFO_WIDTH-1:0]         wdata,
    input  logic [$clog2(FIFO_DEPTH)-1:0] raddr,
    output logic [FIFO_WIDTH-1:0]         rdata
);
    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_lvl.sv
// fifo_lvl: show-ahead FIFO with occupancy count, level thresholds, flush and sticky error flags
module fifo_lvl
    import fifo_lvl_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int AF_LVL     = FIFO_DEPTH - 1,
    parameter int AE_LVL     = 1
) (
    input logic      clk,
    input logic      reset,
    fifo_lvl_if.slave bus
);
    localparam int PW = ptr_w(FIFO_DEPTH);
    if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
        $error("fifo_lvl: FIFO_DEPTH must be a power of two >= 2");
    end
    if (AF_LVL < 1 || AF_LVL > FIFO_DEPTH || AE_LVL < 0 || AE_LVL > FIFO_DEPTH - 1) begin : g_bad_lvl
        $error("fifo_lvl: AF_LVL/AE_LVL out of range");
    end
    logic [PW-1:0] wr_ptr, rd_ptr, count_w;
    logic [FIFO_WIDTH-1:0] rdata;
    logic full_w, empty_w, do_push, do_pop;
    assign count_w          = wr_ptr - rd_ptr;
    assign full_w           = count_w == PW'(FIFO_DEPTH);
    assign empty_w          = count_w == '0;
    assign do_push          = bus.push && !full_w && !bus.flush;
    assign do_pop           = bus.pop && !empty_w && !bus.flush;
    assign bus.count        = count_w;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = count_w >= PW'(AF_LVL);
    assign bus.almost_empty = count_w <= PW'(AE_LVL);
    assign bus.data_out     = empty_w ? '0 : rdata;
    // a fresh error outranks err_clr; flush suppresses error detection entirely
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.ack       <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            wr_ptr        <= bus.flush ? '0 : wr_ptr + PW'(do_push);
            rd_ptr        <= bus.flush ? '0 : rd_ptr + PW'(do_pop);
            bus.ack       <= do_push;
            bus.overflow  <= (bus.push && full_w && !bus.flush) || (bus.overflow && !bus.err_clr);
            bus.underflow <= (bus.pop && empty_w && !bus.flush) || (bus.underflow && !bus.err_clr);
        end
    end
    fifo_lvl_mem #(.FIFO_WIDTH(FIFO_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr[PW-2:0]),
        .wdata (bus.data_in),
        .raddr (rd_ptr[PW-2:0]),
        .rdata (rdata)
    );
endmodule
